hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller and data-memory wait sequencer for the five-stage pipelined CPU. It drives the stall, flush and forwarding controls of the Fetch/Decode, Decode/Execute, Execute/Memory and Memory/Writeback pipeline registers. It resolves load-use hazards, taken-branch flushes, ALU operand forwarding and multi-cycle data-memory accesses, with an optional access timeout. It sits beside the datapath and is the only source of stall/flush/CLR signals for the pipeline registers.

## Interface
- `TIMEOUT`, 16: maximum consecutive wait cycles for a memory access before error; legal range 2..255.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `RA1D`, `RA2D` in 4: source register addresses in Decode.
- `RA1E`, `RA2E` in 4: source register addresses in Execute.
- `WA3E`, `WA3M`, `WA3W` in 4: destination register in Execute, Memory and Writeback.
- `MemToRegE` in 1: the instruction in Execute is a load.
- `RegWriteM`, `RegWriteW` in 1: register write enable in Memory and Writeback.
- `BranchTakenE` in 1: branch resolved taken in Execute.
- `MemReqM` in 1: the instruction in Memory accesses data memory.
- `MemAckM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the PC and the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW` out 1: CLR the F/D, D/E and M/W registers at the next edge.
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 01 ResultW, 10 ALUResultM.
- `MemErr` out 1: sticky memory-timeout error.

## Operation
- FSM states are RUN, MEM_WAIT and ERR. An 8-bit `WaitCnt` accompanies the FSM.
- `memstall = MemReqM & ~MemAckM & (state != ERR)`.
- Transitions:
  - RUN goes to MEM_WAIT on `memstall`, with WaitCnt ← 0.
  - MEM_WAIT goes to RUN on `MemAckM`.
  - MEM_WAIT goes to ERR when `~MemAckM & WaitCnt == TIMEOUT-1`. Otherwise WaitCnt increments.
  - ERR exits only on `RST`.
- Output priority, highest first:
  1. ERR: all Stall* = 1, all Flush* = 0, `MemErr` = 1.
  2. `memstall`: all Stall* = 1, `FlushW` = 1, `FlushD` = `FlushE` = 0. A pending branch is held frozen in E and flushes on release.
  3. `BranchTakenE`: `FlushD` = `FlushE` = 1 and all Stall* = 0. The branch overrides the load-use stall.
  4. `ldstall = MemToRegE & WA3E != 0xF & (WA3E == RA1D | WA3E == RA2D)`: `StallF` = `StallD` = 1 and `FlushE` = 1.
  5. Otherwise all controls are 0.
- Forwarding for operand A (operand B is identical with `RA2E`):
  - 10 if `RegWriteM & WA3M == RA1E & RA1E != 0xF`.
  - Else 01 if `RegWriteW & WA3W == RA1E & RA1E != 0xF`.
  - Else 00.
  - Memory stage wins over Writeback. R15 is never forwarded.
- Forwarding is independent of the FSM state.

## Timing
- Reset values: state RUN, WaitCnt 0, `MemErr` 0.
- Stall, flush and forward outputs are combinational from their inputs and the state, with zero latency. During reset they equal their RUN-state values for the current inputs.
- A request and an ack in the same RUN cycle produce no stall and no state change.
- An ack in MEM_WAIT deasserts the stalls in that same cycle; the state returns to RUN at the next edge.
- Back-to-back accesses with no ack: RUN → MEM_WAIT → RUN takes one RUN cycle only if an ack occurred. A new `memstall` in that RUN cycle re-enters MEM_WAIT with WaitCnt cleared.
- Timeout: ERR is entered at the (TIMEOUT+1)th rising edge after `memstall` is first sampled in RUN.
- An ack arriving in the same cycle as `WaitCnt == TIMEOUT-1` wins: the next state is RUN, not ERR.
- `RST` asserted mid-wait or in ERR returns to RUN immediately (asynchronously) and clears WaitCnt and `MemErr`.

## Configuration
- `HAZARD_MEM_TIMEOUT_EN` defined: the WaitCnt counter and the ERR state are compiled in, as described above.
- Not defined:
  - MEM_WAIT waits indefinitely for `MemAckM`.
  - No counter and no ERR state exist.
  - `MemErr` is tied to 0.
  - `TIMEOUT` is ignored.

## Test plan
- Load-use: `MemToRegE`=1, `WA3E`=3, `RA2D`=3 → `StallF`=`StallD`=`FlushE`=1 for one cycle; next cycle with `MemToRegE`=0 → all 0.
- Forwarding priority:
  - `RegWriteM`=`RegWriteW`=1, `WA3M`=`WA3W`=5, `RA1E`=5 → `ForwardAE`=10.
  - `RA1E`=`WA3M`=`WA3W`=15 → 00.
  - `RegWriteM`=0 with the same addresses → 01.
- Branch versus load-use: `BranchTakenE`=1 with `ldstall` true → `FlushD`=`FlushE`=1 and `StallF`=`StallD`=0.
- Memory wait: `MemReqM`=1 with `MemAckM` low for 3 cycles, then high → all Stall* and `FlushW` = 1 for 3 cycles, 0 in the ack cycle, state back to RUN.
- Timeout, `TIMEOUT`=4 with the macro defined: `MemReqM`=1 with no ack → `MemErr`=1 after the 5th edge and stalls held. Asserting `RST` → `MemErr`=0 and stalls follow the inputs.
- Ack at the limit: `TIMEOUT`=4, ack in the 4th MEM_WAIT cycle → returns to RUN and `MemErr` stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller and data-memory wait sequencer for the
//                five-stage pipeline. It is the only source of the stall,
//                flush and forwarding controls for the F/D, D/E, E/M and M/W
//                pipeline registers.
//
//                It resolves these hazards:
//                  - load-use hazards (stall F/D, bubble into E)
//                  - taken-branch flushes (clear F/D and D/E)
//                  - ALU operand forwarding from Memory or Writeback
//                  - multi-cycle data-memory accesses (freeze the pipeline
//                    and bubble into W until the access is acknowledged)
//
//  Optional    : define HAZARD_MEM_TIMEOUT_EN to compile in an 8-bit wait
//                counter and a sticky ERR state. ERR is entered after
//                TIMEOUT wait cycles without an acknowledge, and is left
//                only by RST. Without the macro, MEM_WAIT waits
//                indefinitely and MemErr is tied to 0.
//
//  Ports       : CLK, RST (async, active-high)
//                RA1D/RA2D            - Decode source registers
//                RA1E/RA2E            - Execute source registers
//                WA3E/WA3M/WA3W       - destination register per stage
//                MemToRegE            - Execute instruction is a load
//                RegWriteM/RegWriteW  - register write enables
//                BranchTakenE         - branch resolved taken in Execute
//                MemReqM/MemAckM      - data-memory request / completion
//                StallF/D/E/M         - hold PC / pipeline registers
//                FlushD/E/W           - clear F/D, D/E, M/W registers
//                ForwardAE/BE         - 00 regfile, 01 ResultW, 10 ALUResultM
//                MemErr               - sticky memory-timeout error
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       MemToRegE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       MemAckM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemErr
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
`ifdef HAZARD_MEM_TIMEOUT_EN
    localparam logic [1:0] S_ERR      = 2'd2;
    // Last wait-count value at which an acknowledge still rescues the access.
    localparam logic [7:0] C_WAIT_LIMIT = 8'(TIMEOUT - 1);
`endif

    // R15 holds the PC and is never a forwarding or load-use target.
    localparam logic [3:0] C_PC_REG = 4'hF;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_in_err;
    logic       w_memstall;
    logic       w_ldstall;

`ifdef HAZARD_MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic [7:0] w_next_wait_cnt;

    assign w_in_err = (r_state == S_ERR);
`else
    // The timeout parameter has no function in this build.
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_in_err         = 1'b0;
`endif

    // An outstanding access that is not completed this cycle freezes the
    // pipeline. In ERR the pipeline is frozen by the error itself instead.
    assign w_memstall = MemReqM & ~MemAckM & ~w_in_err;

    assign w_ldstall  = MemToRegE & (WA3E != C_PC_REG) &
                        ((WA3E == RA1D) | (WA3E == RA2D));

    // ------------------------------------------------------------------------
    // State register (plus wait counter when the timeout is built in)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_RUN;
`ifdef HAZARD_MEM_TIMEOUT_EN
            r_wait_cnt <= 8'd0;
`endif
        end else begin
            r_state    <= w_next_state;
`ifdef HAZARD_MEM_TIMEOUT_EN
            r_wait_cnt <= w_next_wait_cnt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
`ifdef HAZARD_MEM_TIMEOUT_EN
        w_next_wait_cnt = r_wait_cnt;
`endif
        case (r_state)
            S_RUN: begin
                // A request acknowledged in the same cycle never enters
                // MEM_WAIT.
                if (w_memstall) begin
                    w_next_state    = S_MEM_WAIT;
`ifdef HAZARD_MEM_TIMEOUT_EN
                    w_next_wait_cnt = 8'd0;
`endif
                end
            end
            S_MEM_WAIT: begin
                // The acknowledge is checked first, so an ack on the limit
                // cycle still returns to RUN.
                if (MemAckM) begin
                    w_next_state = S_RUN;
                end
`ifdef HAZARD_MEM_TIMEOUT_EN
                else if (r_wait_cnt == C_WAIT_LIMIT) begin
                    w_next_state = S_ERR;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + 8'd1;
                end
`endif
            end
`ifdef HAZARD_MEM_TIMEOUT_EN
            S_ERR: begin
                w_next_state = S_ERR;
            end
`endif
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Stall / flush outputs, in priority order
    // ------------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        MemErr = 1'b0;
        if (w_in_err) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            MemErr = 1'b1;
        end else if (w_memstall) begin
            // Whole pipe frozen; a bubble goes into W. A taken branch stays
            // frozen in E and flushes once the access completes.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (BranchTakenE) begin
            // The fetched/decoded instructions are on the wrong path, so a
            // load-use stall on them is meaningless.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_ldstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Operand forwarding (independent of the FSM); Memory beats Writeback
    // because it holds the younger result.
    // ------------------------------------------------------------------------
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != C_PC_REG)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (WA3W == RA1E) && (RA1E != C_PC_REG)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != C_PC_REG)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (WA3W == RA2E) && (RA2E != C_PC_REG)) begin
            ForwardBE = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl. Stimulus pushes the
//                hand-computed expected outputs for every cycle; a monitor
//                pops and compares on the falling edge.
//                Timeout cases depend on HAZARD_MEM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int C_TIMEOUT = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       MemToRegE, RegWriteM, RegWriteW, BranchTakenE, MemReqM, MemAckM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemErr;

    hazard_ctrl #(.TIMEOUT(C_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected vector: {StallF,D,E,M, FlushD,E,W, ForwardAE, ForwardBE, MemErr}
    typedef struct {
        string       nm;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compares the live outputs against the oldest expectation.
    always @(negedge CLK) begin
        exp_t        e;
        logic [11:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                   ForwardAE, ForwardBE, MemErr};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got %b required %b (SFDEM_FDEW_FA_FB_E)",
                         e.nm, act, e.v);
            end
        end
    end

    task automatic idle();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        MemToRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        BranchTakenE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_t e;
        e.nm = nm;
        e.v  = {st, fl, fa, fb, err};
        sb.push_back(e);
    endtask

    initial begin
        RST = 1'b1;
        idle();

        // ---------------- reset ----------------
        next();
        chk("reset_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        MemToRegE = 1'b1; WA3E = 4'd3; RA2D = 4'd3;
        chk("reset_ldstall", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        next();
        RST = 1'b0;
        idle();
        chk("after_reset", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // ---------------- load-use ----------------
        next();
        MemToRegE = 1'b1; WA3E = 4'd3; RA2D = 4'd3;
        chk("ldstall_ra2d", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        next();
        MemToRegE = 1'b0;
        chk("ldstall_release", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        MemToRegE = 1'b1; WA3E = 4'd7; RA1D = 4'd7; RA2D = 4'd2;
        chk("ldstall_ra1d", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        next();
        WA3E = 4'hF; RA1D = 4'hF;
        chk("ldstall_r15", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        idle();
        MemToRegE = 1'b1; WA3E = 4'd4; RA1D = 4'd5; RA2D = 4'd6;
        chk("ldstall_nomatch", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // ---------------- forwarding ----------------
        next();
        idle();
        RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd5; WA3W = 4'd5; RA1E = 4'd5;
        chk("fwd_m_over_w", 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0);
        next();
        RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF; RA2E = 4'hF;
        chk("fwd_r15", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        RegWriteM = 1'b0; WA3M = 4'd5; WA3W = 4'd5; RA1E = 4'd5; RA2E = 4'd5;
        chk("fwd_w_only", 4'b0000, 3'b000, 2'b01, 2'b01, 1'b0);
        next();
        RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd2; WA3W = 4'd9;
        RA1E = 4'd9; RA2E = 4'd2;
        chk("fwd_split", 4'b0000, 3'b000, 2'b01, 2'b10, 1'b0);

        // ---------------- branch vs load-use ----------------
        next();
        idle();
        BranchTakenE = 1'b1; MemToRegE = 1'b1; WA3E = 4'd3; RA1D = 4'd3;
        chk("branch_over_ld", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);

        // ---------------- memory wait with pending branch ----------------
        next();
        idle();
        MemReqM = 1'b1; BranchTakenE = 1'b1;
        chk("memwait_0", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        next();
        chk("memwait_1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        next();
        chk("memwait_2", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        next();
        MemAckM = 1'b1;
        chk("memwait_ack", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        next();
        idle();
        MemReqM = 1'b1; MemAckM = 1'b1;
        chk("req_ack_same", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        idle();
        chk("idle_after_mem", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // ---------------- timeout ----------------
        next();
        MemReqM = 1'b1;
        chk("to_run", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < C_TIMEOUT; i++) begin
            next();
            chk($sformatf("to_wait_%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        next();
        RegWriteM = 1'b1; WA3M = 4'd6; RA1E = 4'd6;
`ifdef HAZARD_MEM_TIMEOUT_EN
        chk("to_err", 4'b1111, 3'b000, 2'b10, 2'b00, 1'b1);
        next();
        MemReqM = 1'b0; BranchTakenE = 1'b1;
        chk("err_sticky", 4'b1111, 3'b000, 2'b10, 2'b00, 1'b1);
        next();
        RST = 1'b1;
        chk("err_reset", 4'b0000, 3'b110, 2'b10, 2'b00, 1'b0);
        next();
        RST = 1'b0;
        idle();
        chk("after_err_reset", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // ack on the last allowed wait cycle
        next();
        MemReqM = 1'b1;
        chk("lim_run", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < C_TIMEOUT - 1; i++) begin
            next();
            chk($sformatf("lim_wait_%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        next();
        MemAckM = 1'b1;
        chk("lim_ack", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        next();
        idle();
        chk("lim_back_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
`else
        chk("nto_still_wait", 4'b1111, 3'b001, 2'b10, 2'b00, 1'b0);
        next();
        chk("nto_still_wait2", 4'b1111, 3'b001, 2'b10, 2'b00, 1'b0);
        next();
        MemAckM = 1'b1;
        chk("nto_ack", 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0);
        next();
        idle();
        chk("nto_back_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge CLK);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
